fabosc_reset_sequencer: RTL and testbench

Fabric reset sequencer clocked by the on-chip 50 MHz RC oscillator after its global clock buffer (RCOSC_25_50MHZ_O2F). It sits directly downstream of the fabric oscillator block and generates the fabric-wide FAB_RESET_N. It holds that reset through a power-on delay, waits for CCC lock, stretches reset past lock, and flags lock timeouts. All asynchronous inputs are synchronized internally.

---
 rtl/fabosc_reset_sequencer_pkg.sv | 19 +
 rtl/fabosc_reset_sequencer_reset_sync_cell.sv | 24 ++
 rtl/fabosc_reset_sequencer.sv | 135 +++++++++++++
 tb/tb_fabosc_reset_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fabosc_reset_sequencer_pkg.sv
// Shared state codes and default timing constants
// for the fabric oscillator reset sequencer.
package fabosc_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_POR       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STRETCH   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int DEF_POR_CYCLES     = 1024;
    localparam int DEF_LOCK_TIMEOUT   = 50000;
    localparam int DEF_STRETCH_CYCLES = 256;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_CNT_WIDTH      = 17;

endpackage

// File: rtl/fabosc_reset_sequencer_reset_sync_cell.sv
// Parameterized flop chain bringing an asynchronous level
// into the local clock domain; clears low on reset.
module reset_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fabosc_reset_sequencer.sv
// Fabric reset sequencer: power-on hold, CCC lock wait,
// lock stretch and sticky lock-timeout flag.
module fabosc_reset_sequencer
    import fabosc_reset_sequencer_pkg::*;
#(
    parameter int POR_CYCLES     = DEF_POR_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       EXT_RESET_N,
    input  logic       CCC_LOCK,
    output logic       FAB_RESET_N,
    output logic       READY,
    output logic       LOCK_FAULT,
    output logic [2:0] STATE
);

    localparam logic [CNT_WIDTH-1:0] POR_LAST  = CNT_WIDTH'(POR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STR_LAST  = CNT_WIDTH'(STRETCH_CYCLES - 1);

    logic ext_s;
    logic lock_s;

    state_e               state_q;
    state_e               state_nx;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic                 fault_nx;
    logic                 run_nx;

    reset_sync_cell #(
        .STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk  (CLK),
        .rst_n(RESETN),
        .d    (EXT_RESET_N),
        .q    (ext_s)
    );

    reset_sync_cell #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (CLK),
        .rst_n(RESETN),
        .d    (CCC_LOCK),
        .q    (lock_s)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ST_POR;
            cnt_q       <= '0;
            FAB_RESET_N <= 1'b0;
            READY       <= 1'b0;
            LOCK_FAULT  <= 1'b0;
        end else begin
            state_q     <= state_nx;
            cnt_q       <= cnt_nx;
            FAB_RESET_N <= run_nx;
            READY       <= run_nx;
            LOCK_FAULT  <= fault_nx;
        end
    end

    // External reset wins over every state and clears the sticky fault
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        fault_nx = LOCK_FAULT;
        if (!ext_s) begin
            state_nx = ST_POR;
            cnt_nx   = '0;
            fault_nx = 1'b0;
        end else begin
            unique case (state_q)
                ST_POR: begin
                    if (cnt_q == POR_LAST) begin
                        state_nx = ST_WAIT_LOCK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nx = ST_STRETCH;
                        cnt_nx   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_nx = ST_FAULT;
                        cnt_nx   = '0;
                        fault_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
                ST_STRETCH: begin
                    if (!lock_s) begin
                        state_nx = ST_WAIT_LOCK;
                        cnt_nx   = '0;
                    end else if (cnt_q == STR_LAST) begin
                        state_nx = ST_RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nx = ST_WAIT_LOCK;
                        cnt_nx   = '0;
                    end
                end
                ST_FAULT: begin
                    if (lock_s) begin
                        state_nx = ST_STRETCH;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = ST_POR;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign run_nx = (state_nx == ST_RUN);
    assign STATE  = state_q;

endmodule

// File: tb/tb_fabosc_reset_sequencer.sv
// Self-checking bench for fabosc_reset_sequencer using a
// cycle-stamped expectation queue and a boot vector table.
module tb_fabosc_reset_sequencer;

    localparam int POR  = 16;
    localparam int TOUT = 64;
    localparam int STR  = 8;
    localparam int SYNC = 2;
    localparam int CW   = 17;

    // Synchronizers clear on reset, so ext_s needs SYNC edges to rise
    localparam int T_WAIT = POR + SYNC;
    localparam int T_RUN  = POR + 1 + STR + SYNC;

    typedef struct {
        string      name;
        int         at;
        logic [5:0] exp;
    } exp_t;

    typedef struct {
        string      name;
        int         rel;
        logic [5:0] exp;
    } vec_t;

    logic       CLK;
    logic       RESETN;
    logic       EXT_RESET_N;
    logic       CCC_LOCK;
    logic       FAB_RESET_N;
    logic       READY;
    logic       LOCK_FAULT;
    logic [2:0] STATE;

    int   checks;
    int   failures;
    int   cyc;
    int   base;
    exp_t sb[$];
    exp_t cur;
    vec_t boot_tbl[5];

    fabosc_reset_sequencer #(
        .POR_CYCLES    (POR),
        .LOCK_TIMEOUT  (TOUT),
        .STRETCH_CYCLES(STR),
        .SYNC_STAGES   (SYNC),
        .CNT_WIDTH     (CW)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .EXT_RESET_N(EXT_RESET_N),
        .CCC_LOCK   (CCC_LOCK),
        .FAB_RESET_N(FAB_RESET_N),
        .READY      (READY),
        .LOCK_FAULT (LOCK_FAULT),
        .STATE      (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [5:0] obs();
        return {FAB_RESET_N, READY, LOCK_FAULT, STATE};
    endfunction

    function automatic logic [5:0] pk(logic f, logic r, logic l, logic [2:0] s);
        return {f, r, l, s};
    endfunction

    task automatic chk(string nm, logic [5:0] got, logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got{fab,rdy,flt,st}=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic push(string nm, int rel, logic [5:0] v);
        exp_t e;
        e.name = nm;
        e.at   = base + rel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic push_boot();
        for (int i = 0; i < 5; i++) begin
            push(boot_tbl[i].name, boot_tbl[i].rel, boot_tbl[i].exp);
        end
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            if (cur.at < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed: due cycle %0d now %0d", cur.name, cur.at, cyc);
            end else begin
                chk(cur.name, obs(), cur.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        base     = 0;
        boot_tbl[0] = '{"boot_por",     T_WAIT - 1, 6'b000_000};
        boot_tbl[1] = '{"boot_wait",    T_WAIT,     6'b000_001};
        boot_tbl[2] = '{"boot_stretch", T_WAIT + 1, 6'b000_010};
        boot_tbl[3] = '{"boot_str_end", T_RUN - 1,  6'b000_010};
        boot_tbl[4] = '{"boot_run",     T_RUN,      6'b110_011};

        RESETN      = 1'b0;
        EXT_RESET_N = 1'b1;
        CCC_LOCK    = 1'b1;
        step(3);
        chk("reset_values", obs(), 6'b000_000);

        // Boot with lock already present
        RESETN = 1'b1;
        base   = cyc;
        push_boot();
        step(T_RUN + 1);

        // Async reset from RUN, then boot with no lock -> timeout
        RESETN = 1'b0;
        #1;
        chk("async_rst_run", obs(), 6'b000_000);
        CCC_LOCK = 1'b0;
        step(2);
        RESETN = 1'b1;
        base   = cyc;
        push("nolock_wait", T_WAIT, pk(0, 0, 0, 3'd1));
        push("nolock_pre_to", T_WAIT + TOUT - 1, pk(0, 0, 0, 3'd1));
        push("nolock_fault", T_WAIT + TOUT, pk(0, 0, 1, 3'd4));
        push("fault_hold", T_WAIT + TOUT + 3, pk(0, 0, 1, 3'd4));
        step(T_WAIT + TOUT + 3);

        // Lock arrives while in FAULT
        CCC_LOCK = 1'b1;
        base     = cyc;
        push("flt_sync", SYNC, pk(0, 0, 1, 3'd4));
        push("flt_stretch", SYNC + 1, pk(0, 0, 1, 3'd2));
        push("flt_str_end", SYNC + STR, pk(0, 0, 1, 3'd2));
        push("flt_run", SYNC + 1 + STR, pk(1, 1, 1, 3'd3));
        step(SYNC + STR + 2);

        // Lock drop in RUN
        CCC_LOCK = 1'b0;
        base     = cyc;
        push("drop_still_run", SYNC, pk(1, 1, 1, 3'd3));
        push("drop_wait", SYNC + 1, pk(0, 0, 1, 3'd1));
        step(5);
        CCC_LOCK = 1'b1;
        base     = cyc;
        push("relock_str", SYNC + 1, pk(0, 0, 1, 3'd2));
        push("relock_str_end", SYNC + STR, pk(0, 0, 1, 3'd2));
        push("relock_run", SYNC + 1 + STR, pk(1, 1, 1, 3'd3));
        step(SYNC + STR + 2);

        // One-cycle lock glitch at stretch count 5
        CCC_LOCK = 1'b0;
        step(4);
        CCC_LOCK = 1'b1;
        base     = cyc;
        push("glitch_pre", 8, pk(0, 0, 1, 3'd2));
        push("glitch_wait", 9, pk(0, 0, 1, 3'd1));
        push("glitch_restr", 10, pk(0, 0, 1, 3'd2));
        push("glitch_str_end", 17, pk(0, 0, 1, 3'd2));
        push("glitch_run", 18, pk(1, 1, 1, 3'd3));
        step(6);
        CCC_LOCK = 1'b0;
        step(1);
        CCC_LOCK = 1'b1;
        step(12);

        // External reset during RUN clears the sticky fault
        EXT_RESET_N = 1'b0;
        base        = cyc;
        push("ext_run_pre", SYNC, pk(1, 1, 1, 3'd3));
        push("ext_run_por", SYNC + 1, pk(0, 0, 0, 3'd0));
        push("ext_run_hold", 7, pk(0, 0, 0, 3'd0));
        push("ext_run_por_end", 22, pk(0, 0, 0, 3'd0));
        push("ext_run_wait", 23, pk(0, 0, 0, 3'd1));
        push("ext_run_str", 24, pk(0, 0, 0, 3'd2));
        push("ext_run_run", 32, pk(1, 1, 0, 3'd3));
        step(5);
        EXT_RESET_N = 1'b1;
        step(28);

        // Drive into FAULT, then external reset
        CCC_LOCK = 1'b0;
        base     = cyc;
        push("f2_wait", SYNC + 1, pk(0, 0, 0, 3'd1));
        push("f2_pre_to", SYNC + TOUT, pk(0, 0, 0, 3'd1));
        push("f2_fault", SYNC + 1 + TOUT, pk(0, 0, 1, 3'd4));
        step(70);
        EXT_RESET_N = 1'b0;
        base        = cyc;
        push("ext_flt_pre", SYNC, pk(0, 0, 1, 3'd4));
        push("ext_flt_por", SYNC + 1, pk(0, 0, 0, 3'd0));
        push("ext_flt_por_end", 22, pk(0, 0, 0, 3'd0));
        push("ext_flt_wait", 23, pk(0, 0, 0, 3'd1));
        step(5);
        EXT_RESET_N = 1'b1;
        step(19);

        // Async reset mid-STRETCH, then full reboot
        CCC_LOCK = 1'b1;
        base     = cyc;
        push("mid_str", 5, pk(0, 0, 0, 3'd2));
        step(6);
        RESETN = 1'b0;
        #1;
        chk("async_rst_stretch", obs(), 6'b000_000);
        step(3);
        RESETN = 1'b1;
        base   = cyc;
        push_boot();
        step(T_RUN + 3);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
